// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Function : Takes a byte-serial program stream over a valid/ready handshake,
//            packs the bytes little-endian into ISIZE-bit instruction words and
//            writes them to instruction memory at addresses 0, 1, 2, ...
//            The fetch stage is held off while a load is running.
// Revision : 1.0  initial release
// ============================================================================
module instr_mem_loader #(
  parameter int ISIZE = 32,
  parameter int MSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MSIZE:0]   word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [MSIZE-1:0] mem_addr,
  output logic [ISIZE-1:0] mem_wdata,
  output logic             fetch_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Bytes per word is fixed by the word width.
  localparam int BPW = ISIZE / 8;
  // Byte counter needs at least one bit even for single-byte words.
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [BCW-1:0] BYTE_ONE  = BCW'(1);
  localparam logic [MSIZE:0] WORD_ONE  = (MSIZE + 1)'(1);
  // Memory depth; word_count may equal this but not exceed it.
  localparam logic [MSIZE:0] DEPTH     = {1'b1, {MSIZE{1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [BCW-1:0]   byte_cnt;
  logic [MSIZE:0]   word_idx;
  logic [MSIZE:0]   word_total;
  logic [ISIZE-1:0] asm_buf;
  logic [ISIZE-1:0] word_full;
  logic             accept;
  logic             last_byte;
  logic             last_word;
  logic             start_take;
  logic             start_ok;

  assign accept     = byte_valid && byte_ready;
  assign last_byte  = (byte_cnt == LAST_BYTE);
  // word_idx is one bit wider than the address so a full-depth count compares cleanly.
  assign last_word  = ((word_idx + WORD_ONE) == word_total);
  assign start_take = start && ((state == S_IDLE) || (state == S_DONE));
  assign start_ok   = (word_count != '0) && (word_count <= DEPTH);

  // Merge the incoming byte into its lane of the partially assembled word.
  always_comb begin
    word_full = asm_buf;
    for (int k = 0; k < BPW; k++) begin
      if (byte_cnt == BCW'(k)) begin
        word_full[8*k +: 8] = byte_data;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start && start_ok) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && last_byte && last_word) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    fetch_hold = 1'b0;
    case (state)
      S_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        fetch_hold = 1'b1;
      end
      S_FLUSH: begin
        busy       = 1'b1;
        fetch_hold = 1'b1;
      end
      default: begin
        byte_ready = 1'b0;
      end
    endcase
  end

  // Counters, byte assembly, memory write port and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      word_idx   <= '0;
      word_total <= '0;
      asm_buf    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse after each completed word.
      mem_we <= 1'b0;

      if (start_take) begin
        done <= 1'b0;
        if (start_ok) begin
          word_total <= word_count;
          byte_cnt   <= '0;
          word_idx   <= '0;
          error      <= 1'b0;
        end else begin
          error <= 1'b1;
        end
      end

      if (accept) begin
        if (last_byte) begin
          mem_we    <= 1'b1;
          mem_wdata <= word_full;
          mem_addr  <= word_idx[MSIZE-1:0];
          word_idx  <= word_idx + WORD_ONE;
          byte_cnt  <= '0;
        end else begin
          asm_buf  <= word_full;
          byte_cnt <= byte_cnt + BYTE_ONE;
        end
      end

      if (state == S_FLUSH) begin
        done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Function : Directed self-checking bench for instr_mem_loader
//            (ISIZE=32, MSIZE=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_mem_loader;

  localparam int ISIZE = 32;
  localparam int MSIZE = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [MSIZE:0]   word_count;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             mem_we;
  logic [MSIZE-1:0] mem_addr;
  logic [ISIZE-1:0] mem_wdata;
  logic             fetch_hold;
  logic             busy;
  logic             done;
  logic             error;

  int errors = 0;
  int checks = 0;

  // Write log filled from the memory port on every falling edge.
  int               wr_n = 0;
  logic [MSIZE-1:0] wr_addr [64];
  logic [ISIZE-1:0] wr_data [64];

  logic [7:0] seq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  instr_mem_loader #(.ISIZE(ISIZE), .MSIZE(MSIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .fetch_hold (fetch_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write pulse the DUT issues.
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
      end
      wr_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic issue_start(input logic [MSIZE:0] n);
    start      = 1'b1;
    word_count = n;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, fetch_hold, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b we=%b addr=%h wdata=%h hold=%b busy=%b done=%b err=%b, required all 0",
               byte_ready, mem_we, mem_addr, mem_wdata, fetch_hold, busy, done, error);
    end
    rst = 1'b0;
    step();
    base = wr_n;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) step();
    byte_valid = 1'b0;
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b required 0", byte_ready);
    end
    checks++;
    if ((wr_n - base) !== 0) begin
      errors++;
      $display("FAIL idle_no_write: got %0d writes required 0", wr_n - base);
    end
    checks++;
    if ({busy, fetch_hold} !== 2'b00) begin
      errors++;
      $display("FAIL idle_busy_hold: got %b required 00", {busy, fetch_hold});
    end
  endtask

  task automatic test_two_word();
    int base;
    base = wr_n;
    issue_start(2);
    checks++;
    if ({byte_ready, fetch_hold, busy, done} !== 4'b1110) begin
      errors++;
      $display("FAIL load_entry: got ready/hold/busy/done=%b required 1110", {byte_ready, fetch_hold, busy, done});
    end
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1;
      byte_data  = seq[i];
      step();
      if (i == 3) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 3'd0, 32'h44332211}) begin
          errors++;
          $display("FAIL word0_write: got we=%b addr=%h data=%h required we=1 addr=0 data=44332211", mem_we, mem_addr, mem_wdata);
        end
      end else if (i == 7) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 3'd1, 32'h88776655}) begin
          errors++;
          $display("FAIL word1_write: got we=%b addr=%h data=%h required we=1 addr=1 data=88776655", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({byte_ready, fetch_hold, busy, done} !== 4'b0110) begin
          errors++;
          $display("FAIL flush_state: got ready/hold/busy/done=%b required 0110", {byte_ready, fetch_hold, busy, done});
        end
      end else begin
        checks++;
        if ({mem_we, fetch_hold} !== 2'b01) begin
          errors++;
          $display("FAIL mid_load_%0d: got we/hold=%b required 01", i, {mem_we, fetch_hold});
        end
      end
    end
    byte_valid = 1'b0;
    step();
    checks++;
    if ({done, fetch_hold, busy, mem_we, byte_ready} !== 5'b10000) begin
      errors++;
      $display("FAIL done_state: got done/hold/busy/we/ready=%b required 10000", {done, fetch_hold, busy, mem_we, byte_ready});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== {3'd1, 32'h88776655}) begin
      errors++;
      $display("FAIL done_hold_values: got addr=%h data=%h required addr=1 data=88776655", mem_addr, mem_wdata);
    end
    checks++;
    if ((wr_n - base) !== 2) begin
      errors++;
      $display("FAIL two_word_count: got %0d writes required 2", wr_n - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int sent;
    int ready_bad;
    logic pat;
    base = wr_n;
    sent = 0;
    ready_bad = 0;
    issue_start(2);
    for (int c = 0; c < 40 && sent < 8; c++) begin
      pat = ((c % 4) == 0) || ((c % 4) == 3);
      if (byte_ready !== 1'b1) ready_bad++;
      byte_valid = pat;
      byte_data  = pat ? seq[sent] : 8'hFF;
      step();
      if (pat) sent++;
    end
    byte_valid = 1'b0;
    step();
    checks++;
    if (ready_bad !== 0) begin
      errors++;
      $display("FAIL bp_ready: got %0d cycles with ready low required 0", ready_bad);
    end
    checks++;
    if ((wr_n - base) !== 2) begin
      errors++;
      $display("FAIL bp_write_count: got %0d writes required 2", wr_n - base);
    end
    checks++;
    if ({wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]} !==
        {3'd0, 32'h44332211, 3'd1, 32'h88776655}) begin
      errors++;
      $display("FAIL bp_write_data: got %h/%h %h/%h required 0/44332211 1/88776655",
               wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: got %b required 1", done);
    end
  endtask

  task automatic test_bad_start();
    int base;
    do_reset();
    issue_start(0);
    checks++;
    if ({error, busy, fetch_hold, byte_ready, done} !== 5'b10000) begin
      errors++;
      $display("FAIL bad_start_zero: got err/busy/hold/ready/done=%b required 10000", {error, busy, fetch_hold, byte_ready, done});
    end
    issue_start(9);
    checks++;
    if ({error, busy} !== 2'b10) begin
      errors++;
      $display("FAIL bad_start_over: got err/busy=%b required 10", {error, busy});
    end
    base = wr_n;
    issue_start(1);
    checks++;
    if ({error, busy, byte_ready} !== 3'b011) begin
      errors++;
      $display("FAIL good_start_clears: got err/busy/ready=%b required 011", {error, busy, byte_ready});
    end
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    step();
    checks++;
    if ((wr_n - base) !== 1 || wr_addr[base] !== 3'd0 || wr_data[base] !== 32'hEFBEADDE || done !== 1'b1) begin
      errors++;
      $display("FAIL one_word_load: got writes=%0d addr=%h data=%h done=%b required 1 0 efbeadde 1",
               wr_n - base, wr_addr[base], wr_data[base], done);
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    base = wr_n;
    issue_start(3);
    for (int i = 0; i < 6; i++) send_byte(seq[i]);
    rst = 1'b1;
    #1;
    checks++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, fetch_hold, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ready=%b we=%b addr=%h wdata=%h hold=%b busy=%b done=%b err=%b, required all 0",
               byte_ready, mem_we, mem_addr, mem_wdata, fetch_hold, busy, done, error);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ((wr_n - base) !== 1 || wr_addr[base] !== 3'd0 || wr_data[base] !== 32'h44332211) begin
      errors++;
      $display("FAIL midreset_writes: got writes=%0d addr=%h data=%h required 1 0 44332211",
               wr_n - base, wr_addr[base], wr_data[base]);
    end
    base = wr_n;
    issue_start(1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    step();
    checks++;
    if ((wr_n - base) !== 1 || wr_addr[base] !== 3'd0 || wr_data[base] !== 32'h04030201 || done !== 1'b1) begin
      errors++;
      $display("FAIL fresh_load: got writes=%0d addr=%h data=%h done=%b required 1 0 04030201 1",
               wr_n - base, wr_addr[base], wr_data[base], done);
    end
  endtask

  task automatic test_full_depth();
    int base;
    logic [ISIZE-1:0] exp;
    base = wr_n;
    issue_start(8);
    for (int i = 0; i < 32; i++) begin
      start      = (i == 10) || (i == 31);
      word_count = 4'd1;
      byte_valid = 1'b1;
      byte_data  = 8'(64 + i);
      step();
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    checks++;
    if ({byte_ready, busy, fetch_hold} !== 3'b011) begin
      errors++;
      $display("FAIL full_flush: got ready/busy/hold=%b required 011", {byte_ready, busy, fetch_hold});
    end
    step();
    checks++;
    if ({done, error, busy} !== 3'b100) begin
      errors++;
      $display("FAIL full_done: got done/err/busy=%b required 100", {done, error, busy});
    end
    checks++;
    if ((wr_n - base) !== 8) begin
      errors++;
      $display("FAIL full_count: got %0d writes required 8", wr_n - base);
    end
    for (int n = 0; n < 8; n++) begin
      exp = {8'(67 + 4*n), 8'(66 + 4*n), 8'(65 + 4*n), 8'(64 + 4*n)};
      checks++;
      if (wr_addr[base+n] !== 3'(n) || wr_data[base+n] !== exp) begin
        errors++;
        $display("FAIL full_word_%0d: got addr=%h data=%h required addr=%h data=%h",
                 n, wr_addr[base+n], wr_data[base+n], 3'(n), exp);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    test_reset();
    test_two_word();
    test_backpressure();
    test_bad_start();
    test_reset_mid_load();
    test_full_depth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
